dispense_sequencer: RTL and testbench

- Consumer side of the drink-selector interface: accepts the 4-bit selection code the selector FSM produces and executes the physical dispense sequence.
- Sequence: cup drop, water fill (optional heat), optional mix, serve.
- Timed, single-clock Moore FSM with a countdown timer and a valid/ready handshake toward the selector.
- Reports completion or fault back to the selector side.

---
 rtl/dispense_pkg.sv | 46 ++++
 rtl/dispense_timer.sv | 27 ++
 rtl/dispense_sequencer.sv | 119 +++++++++++
 tb/tb_dispense_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dispense_pkg.sv
// Shared definitions for the dispense sequencer: state encodings, product
// codes and the recipe lookup.
package dispense_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CUP  = 3'd1,
    S_FILL = 3'd2,
    S_MIX  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] CODE_COFFEE    = 4'd1;
  localparam logic [3:0] CODE_TEA       = 4'd2;
  localparam logic [3:0] CODE_MILK      = 4'd3;
  localparam logic [3:0] CODE_CHOCOLATE = 4'd4;
  localparam logic [3:0] CODE_WATER     = 4'd5;
  localparam logic [3:0] CODE_LEMONADE  = 4'd6;

  typedef struct packed {
    logic fill_long;
    logic heat;
    logic mix;
  } recipe_t;

  function automatic logic code_valid(input logic [3:0] code);
    return (code >= CODE_COFFEE) && (code <= CODE_LEMONADE);
  endfunction

  // Invalid codes map to an all-zero recipe; they never reach a timed state.
  function automatic recipe_t recipe(input logic [3:0] code);
    recipe_t r;
    case (code)
      CODE_COFFEE:    r = '{fill_long: 1'b1, heat: 1'b1, mix: 1'b1};
      CODE_TEA:       r = '{fill_long: 1'b1, heat: 1'b1, mix: 1'b0};
      CODE_MILK:      r = '{fill_long: 1'b0, heat: 1'b0, mix: 1'b1};
      CODE_CHOCOLATE: r = '{fill_long: 1'b1, heat: 1'b1, mix: 1'b1};
      CODE_WATER:     r = '{fill_long: 1'b0, heat: 1'b0, mix: 1'b0};
      CODE_LEMONADE:  r = '{fill_long: 1'b0, heat: 1'b0, mix: 1'b1};
      default:        r = '{fill_long: 1'b0, heat: 1'b0, mix: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a
// timed state.
module dispense_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (areset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dispense_sequencer.sv
// Timed Moore FSM that runs cup drop, fill, optional mix and serve for a
// selection code received over a valid/ready handshake.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int T_CUP   = 4,
  parameter int T_SHORT = 8,
  parameter int T_LONG  = 16,
  parameter int T_MIX   = 6,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       sel_valid,
  input  logic [3:0] sel,
  output logic       sel_ready,
  input  logic       cup_present,
  input  logic       abort,
  output logic       cup_drop,
  output logic       water_valve,
  output logic       heater,
  output logic       mixer,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_o
);

  localparam logic [TW-1:0] CUP_LD   = TW'(T_CUP - 1);
  localparam logic [TW-1:0] SHORT_LD = TW'(T_SHORT - 1);
  localparam logic [TW-1:0] LONG_LD  = TW'(T_LONG - 1);
  localparam logic [TW-1:0] MIX_LD   = TW'(T_MIX - 1);

  state_t        state;
  state_t        nxt;
  logic [3:0]    code;
  recipe_t       rcp;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_zero;

  assign rcp     = recipe(code);
  assign state_o = state;

  // The timer is reloaded for the following state on every edge that could
  // enter it; a reload on a path that ends in ERR is harmless.
  always_comb begin
    timer_load  = (state == S_IDLE) ||
                  (((state == S_CUP) || (state == S_FILL)) && timer_zero);
    timer_value = '0;
    case (state)
      S_IDLE:  timer_value = CUP_LD;
      S_CUP:   timer_value = rcp.fill_long ? LONG_LD : SHORT_LD;
      S_FILL:  timer_value = MIX_LD;
      default: timer_value = '0;
    endcase
  end

  dispense_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .areset     (areset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Abort and cup loss win over timer expiry.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (sel_valid) nxt = code_valid(sel) ? S_CUP : S_ERR;
      end
      S_CUP: begin
        if (abort)           nxt = S_ERR;
        else if (timer_zero) nxt = cup_present ? S_FILL : S_ERR;
      end
      S_FILL: begin
        if (abort || !cup_present) nxt = S_ERR;
        else if (timer_zero)       nxt = rcp.mix ? S_MIX : S_DONE;
      end
      S_MIX: begin
        if (abort || !cup_present) nxt = S_ERR;
        else if (timer_zero)       nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (areset) begin
      state       <= S_IDLE;
      code        <= '0;
      sel_ready   <= 1'b1;
      busy        <= 1'b0;
      cup_drop    <= 1'b0;
      water_valve <= 1'b0;
      heater      <= 1'b0;
      mixer       <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state <= nxt;
      if ((state == S_IDLE) && sel_valid) code <= sel;
      sel_ready   <= (nxt == S_IDLE);
      busy        <= (nxt != S_IDLE);
      cup_drop    <= (nxt == S_CUP);
      water_valve <= (nxt == S_FILL);
      heater      <= (nxt == S_FILL) && rcp.heat;
      mixer       <= (nxt == S_MIX);
      done        <= (nxt == S_DONE);
      error       <= (nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: a table of whole-run vectors with
// hand-computed cycle windows, plus reset and held-valid sequences.
module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       areset;
  logic       sel_valid;
  logic [3:0] sel;
  logic       sel_ready;
  logic       cup_present;
  logic       abort;
  logic       cup_drop, water_valve, heater, mixer, busy, done, error;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dispense_sequencer dut (
    .clk         (clk),
    .areset      (areset),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .sel_ready   (sel_ready),
    .cup_present (cup_present),
    .abort       (abort),
    .cup_drop    (cup_drop),
    .water_valve (water_valve),
    .heater      (heater),
    .mixer       (mixer),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .state_o     (state_o)
  );

  // Cycle 0 is the transfer cycle; empty windows use lo > hi, absent events -1.
  typedef struct {
    string name;
    int    sel;
    bit    cup;
    int    cup_lo,  cup_hi;
    int    fill_lo, fill_hi;
    bit    heat;
    int    mix_lo,  mix_hi;
    int    done_at, err_at;
    int    abort_at, cupoff_at;
  } vec_t;

  // Packed as {sel_ready, busy, cup_drop, water_valve, heater, mixer, done, error, state[2:0]}
  function automatic logic [10:0] outs();
    return {sel_ready, busy, cup_drop, water_valve, heater, mixer, done, error, state_o};
  endfunction

  function automatic logic [10:0] expect_at(vec_t v, int c);
    logic in_cup, in_fill, in_mix, is_done, is_err, bsy;
    logic [2:0] st;
    int last;
    last    = (v.done_at >= 0) ? v.done_at : v.err_at;
    in_cup  = (c >= v.cup_lo)  && (c <= v.cup_hi);
    in_fill = (c >= v.fill_lo) && (c <= v.fill_hi);
    in_mix  = (c >= v.mix_lo)  && (c <= v.mix_hi);
    is_done = (c == v.done_at);
    is_err  = (c == v.err_at);
    bsy     = (c >= 1) && (c <= last);
    st = 3'd0;
    if (in_cup)  st = 3'd1;
    if (in_fill) st = 3'd2;
    if (in_mix)  st = 3'd3;
    if (is_done) st = 3'd4;
    if (is_err)  st = 3'd5;
    return {~bsy, bsy, in_cup, in_fill, in_fill & v.heat, in_mix, is_done, is_err, st};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (rdy busy cup fill heat mix done err st)",
               name, act, exp);
    end
  endtask

  vec_t vecs[$];
  vec_t coffee, water;
  localparam logic [10:0] IDLE_OUT = 11'b10_000000_000;
  localparam logic [10:0] ERR_OUT  = 11'b01_000001_101;

  initial begin
    //          name           sel cup cup    fill  heat mix    done err abort cupoff
    vecs.push_back('{"coffee",    1, 1, 1, 4, 5, 20, 1, 21, 26, 27, -1, -1, 1000});
    vecs.push_back('{"tea",       2, 1, 1, 4, 5, 20, 1,  0, -1, 21, -1, -1, 1000});
    vecs.push_back('{"milk",      3, 1, 1, 4, 5, 12, 0, 13, 18, 19, -1, -1, 1000});
    vecs.push_back('{"chocolate", 4, 1, 1, 4, 5, 20, 1, 21, 26, 27, -1, -1, 1000});
    vecs.push_back('{"water",     5, 1, 1, 4, 5, 12, 0,  0, -1, 13, -1, -1, 1000});
    vecs.push_back('{"lemonade",  6, 1, 1, 4, 5, 12, 0, 13, 18, 19, -1, -1, 1000});
    vecs.push_back('{"invalid9",  9, 1, 0, -1, 0, -1, 0, 0, -1, -1, 1, -1, 1000});
    vecs.push_back('{"invalid0",  0, 1, 0, -1, 0, -1, 0, 0, -1, -1, 1, -1, 1000});
    vecs.push_back('{"invalid15",15, 1, 0, -1, 0, -1, 0, 0, -1, -1, 1, -1, 1000});
    vecs.push_back('{"nocup",     2, 0, 1, 4, 0, -1, 1,  0, -1, -1, 5, -1, 1000});
    vecs.push_back('{"abortfill", 1, 1, 1, 4, 5, 10, 1,  0, -1, -1, 11, 10, 1000});
    vecs.push_back('{"abortcup",  1, 1, 1, 2, 0, -1, 1,  0, -1, -1, 3,  2, 1000});
    vecs.push_back('{"cupoffmix", 1, 1, 1, 4, 5, 20, 1, 21, 22, -1, 23, -1, 22});
    vecs.push_back('{"cupofffill",3, 1, 1, 4, 5,  6, 0,  0, -1, -1, 7, -1, 6});
    coffee = vecs[0];
    water  = vecs[4];

    areset = 1'b1; sel_valid = 1'b0; sel = '0; cup_present = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    check("reset", outs(), IDLE_OUT);

    // Runs are chained: each transfer happens in the first IDLE cycle of the last.
    foreach (vecs[i]) begin
      int last;
      last = ((vecs[i].done_at >= 0) ? vecs[i].done_at : vecs[i].err_at) + 1;
      check($sformatf("%s c0", vecs[i].name), outs(), expect_at(vecs[i], 0));
      sel_valid   = 1'b1;
      sel         = 4'(vecs[i].sel);
      cup_present = vecs[i].cup;
      abort       = (vecs[i].abort_at == 0);
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        sel_valid = 1'b0;
        check($sformatf("%s c%0d", vecs[i].name, c), outs(), expect_at(vecs[i], c));
        abort       = (c == vecs[i].abort_at);
        cup_present = (c >= vecs[i].cupoff_at) ? 1'b0 : vecs[i].cup;
      end
      abort = 1'b0;
      cup_present = 1'b1;
    end

    // Reset in cycle 7 of a coffee run returns straight to IDLE.
    sel_valid = 1'b1; sel = 4'd1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      sel_valid = 1'b0;
      check($sformatf("rstrun c%0d", c), outs(), expect_at(coffee, c));
    end
    areset = 1'b1;
    @(negedge clk);
    check("midreset", outs(), IDLE_OUT);
    areset = 1'b0;
    @(negedge clk);
    check("post reset idle", outs(), IDLE_OUT);

    // sel_valid held through a water run must not start anything until IDLE.
    sel_valid = 1'b1; sel = 4'd5;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      sel = 4'd9;
      check($sformatf("held c%0d", c), outs(), expect_at(water, c));
    end
    @(negedge clk);
    sel_valid = 1'b0;
    check("held late transfer", outs(), ERR_OUT);
    @(negedge clk);
    check("held idle", outs(), IDLE_OUT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
